// File: rtl/eth_mac_conf_pkg.sv
// eth_mac_conf_pkg: register map, CTRL bits, vector bit positions, FSM states and vector packing
package eth_mac_conf_pkg;
    localparam logic [2:0] ADDR_MAC_LO = 3'd0;
    localparam logic [2:0] ADDR_MAC_HI = 3'd1;
    localparam logic [2:0] ADDR_MTU    = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam int CTRL_TX_EN       = 0;
    localparam int CTRL_RX_EN       = 1;
    localparam int CTRL_VLAN        = 2;
    localparam int CTRL_JUMBO       = 3;
    localparam int CTRL_LEN_CHK_DIS = 4;
    localparam int CTRL_LT_CHK_DIS  = 5;
    localparam int VEC_MAC_LSB     = 32;
    localparam int VEC_MTU_LSB     = 16;
    localparam int VEC_LEN_CHK_DIS = 9;
    localparam int VEC_LT_CHK_DIS  = 8;
    localparam int VEC_JUMBO       = 4;
    localparam int VEC_VLAN        = 2;
    localparam int VEC_EN          = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_QUIESCE, ST_LOAD, ST_ENABLE} state_t;
    function automatic logic [79:0] pack_vec(input logic [47:0] mac, input logic [14:0] mtu,
                                             input logic [5:0] ctrl, input logic en, input logic rx);
        logic [79:0] v;
        v = '0;
        v[79:VEC_MAC_LSB] = mac;
        v[VEC_MTU_LSB +: 15] = mtu;
        v[VEC_JUMBO] = ctrl[CTRL_JUMBO];
        v[VEC_VLAN] = ctrl[CTRL_VLAN];
        v[VEC_EN] = en;
        v[VEC_LEN_CHK_DIS] = rx & ctrl[CTRL_LEN_CHK_DIS];
        v[VEC_LT_CHK_DIS] = rx & ctrl[CTRL_LT_CHK_DIS];
        return v;
    endfunction
endpackage

// File: rtl/eth_mac_conf_port.sv
// eth_mac_conf_port: one port's shadow/active registers, commit FSM and TX/RX vector packing
module eth_mac_conf_port
    import eth_mac_conf_pkg::*;
#(
    parameter logic [47:0] DEFAULT_MAC  = 48'h001122334455,
    parameter int          DEFAULT_MTU  = 1518,
    parameter int          QUIET_CYCLES = 16,
    parameter int          TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic        commit,
    input  logic        tx_busy,
    input  logic        rx_busy,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [79:0] tx_vec,
    output logic [79:0] rx_vec
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_nx;
    logic [47:0] sh_mac, act_mac;
    logic [14:0] sh_mtu, act_mtu;
    logic [5:0] sh_ctrl, act_ctrl;
    logic pending, sticky, quiet, qdone, tdone, en_mask;
    logic [CW-1:0] qcnt, tcnt;

    assign quiet = ~tx_busy & ~rx_busy;
    assign qdone = quiet && (qcnt == CW'(QUIET_CYCLES - 1));
    assign tdone = tcnt == CW'(TIMEOUT - 1);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = (commit || pending) ? ST_QUIESCE : ST_IDLE;
            ST_QUIESCE: state_nx = (qdone || tdone) ? ST_LOAD : ST_QUIESCE;
            ST_LOAD:    state_nx = ST_ENABLE;
            default:    state_nx = ST_IDLE;
        endcase
        en_mask = (state == ST_QUIESCE) || (state == ST_LOAD);
        busy = (state != ST_IDLE) || pending;
        done = state == ST_ENABLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= 1'b0;
            sticky   <= 1'b0;
            qcnt     <= '0;
            tcnt     <= '0;
            sh_mac   <= DEFAULT_MAC;
            act_mac  <= DEFAULT_MAC;
            sh_mtu   <= 15'(DEFAULT_MTU);
            act_mtu  <= 15'(DEFAULT_MTU);
            sh_ctrl  <= 6'h3f;
            act_ctrl <= 6'h3f;
        end else begin
            state   <= state_nx;
            pending <= (state != ST_IDLE) && (pending || commit);
            qcnt    <= (state == ST_QUIESCE && quiet && !qdone) ? qcnt + 1'b1 : '0;
            tcnt    <= (state == ST_QUIESCE && state_nx == ST_QUIESCE) ? tcnt + 1'b1 : '0;
            if (state == ST_QUIESCE && tdone && !qdone)
                sticky <= 1'b1;
            else if (wr_en && addr == ADDR_STATUS)
                sticky <= 1'b0;
            if (wr_en && addr == ADDR_MAC_LO) sh_mac[31:0] <= wdata;
            if (wr_en && addr == ADDR_MAC_HI) sh_mac[47:32] <= wdata[15:0];
            if (wr_en && addr == ADDR_MTU) sh_mtu <= wdata[14:0];
            if (wr_en && addr == ADDR_CTRL) sh_ctrl <= wdata[5:0];
            // snapshot taken on entry to LOAD; enables stay masked until ENABLE
            if (state == ST_QUIESCE && state_nx == ST_LOAD) begin
                act_mac  <= sh_mac;
                act_mtu  <= sh_mtu;
                act_ctrl <= sh_ctrl;
            end
        end
    end

    assign rdata = (addr == ADDR_MAC_LO) ? sh_mac[31:0] :
                   (addr == ADDR_MAC_HI) ? {16'b0, sh_mac[47:32]} :
                   (addr == ADDR_MTU)    ? {17'b0, sh_mtu} :
                   (addr == ADDR_CTRL)   ? {26'b0, sh_ctrl} :
                   (addr == ADDR_STATUS) ? {30'b0, busy, sticky} : '0;
    assign tx_vec = pack_vec(act_mac, act_mtu, act_ctrl, act_ctrl[CTRL_TX_EN] & ~en_mask, 1'b0);
    assign rx_vec = pack_vec(act_mac, act_mtu, act_ctrl, act_ctrl[CTRL_RX_EN] & ~en_mask, 1'b1);
endmodule

// File: rtl/eth_mac_conf_ctrl.sv
// eth_mac_conf_ctrl: per-port MAC configuration with atomic commit; register readback
// is built only when ETH_MAC_CONF_READBACK_EN is defined
module eth_mac_conf_ctrl
    import eth_mac_conf_pkg::*;
#(
    parameter int          NPORT        = 1,
    parameter logic [47:0] DEFAULT_MAC  = 48'h001122334455,
    parameter int          DEFAULT_MTU  = 1518,
    parameter int          QUIET_CYCLES = 16,
    parameter int          TIMEOUT      = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic                  cfg_rd_en,
    input  logic [1:0]            cfg_port,
    input  logic [2:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    output logic                  cfg_rvalid,
    input  logic [NPORT-1:0]      cfg_commit,
    input  logic [NPORT-1:0]      mac_tx_busy,
    input  logic [NPORT-1:0]      mac_rx_busy,
    output logic [NPORT-1:0]      cfg_busy,
    output logic [NPORT-1:0]      cfg_done,
    output logic [80*NPORT-1:0]   mac_tx_configuration_vector,
    output logic [80*NPORT-1:0]   mac_rx_configuration_vector
);
    logic [NPORT-1:0][31:0] prd;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        eth_mac_conf_port #(
            .DEFAULT_MAC(DEFAULT_MAC + 48'(p)),
            .DEFAULT_MTU(DEFAULT_MTU),
            .QUIET_CYCLES(QUIET_CYCLES),
            .TIMEOUT(TIMEOUT)
        ) u_port (
            .clk(clk),
            .rst(rst),
            .wr_en(cfg_wr_en && cfg_port == 2'(p)),
            .addr(cfg_addr),
            .wdata(cfg_wdata),
            .commit(cfg_commit[p]),
            .tx_busy(mac_tx_busy[p]),
            .rx_busy(mac_rx_busy[p]),
            .rdata(prd[p]),
            .busy(cfg_busy[p]),
            .done(cfg_done[p]),
            .tx_vec(mac_tx_configuration_vector[80*p +: 80]),
            .rx_vec(mac_rx_configuration_vector[80*p +: 80])
        );
    end

`ifdef ETH_MAC_CONF_READBACK_EN
    logic [31:0] rsel;
    always_comb begin
        rsel = '0;
        for (int i = 0; i < NPORT; i++)
            if (cfg_port == 2'(i)) rsel = prd[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_rdata  <= '0;
            cfg_rvalid <= 1'b0;
        end else begin
            cfg_rvalid <= cfg_rd_en;
            cfg_rdata  <= cfg_rd_en ? rsel : '0;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = cfg_rd_en ^ (^prd);
    assign cfg_rdata = '0;
    assign cfg_rvalid = 1'b0;
`endif
endmodule

// File: tb/tb_eth_mac_conf_ctrl.sv
// tb_eth_mac_conf_ctrl: directed checks of commit timing, timeout, pending merge and reset
module tb_eth_mac_conf_ctrl;
    localparam int NPORT = 2;
`ifdef ETH_MAC_CONF_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [79:0] TX0_DEF = {48'h001122334455, 1'b0, 15'd1518, 16'h0016};
    localparam logic [79:0] RX0_DEF = {48'h001122334455, 1'b0, 15'd1518, 16'h0316};
    localparam logic [79:0] TX1_DEF = {48'h001122334456, 1'b0, 15'd1518, 16'h0016};

    logic clk = 1'b0, rst = 1'b1, cfg_wr_en = 1'b0, cfg_rd_en = 1'b0;
    logic [1:0] cfg_port = '0;
    logic [2:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0, cfg_rdata;
    logic cfg_rvalid;
    logic [NPORT-1:0] cfg_commit = '0, mac_tx_busy = '0, mac_rx_busy = '0, cfg_busy, cfg_done;
    logic [80*NPORT-1:0] txv, rxv;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    eth_mac_conf_ctrl #(.NPORT(NPORT), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en),
        .cfg_port(cfg_port), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid), .cfg_commit(cfg_commit),
        .mac_tx_busy(mac_tx_busy), .mac_rx_busy(mac_rx_busy), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .mac_tx_configuration_vector(txv),
        .mac_rx_configuration_vector(rxv)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] p, input logic [2:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_port = p; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] p, input logic [2:0] a, output logic [31:0] d, output logic v);
        cfg_rd_en = 1'b1; cfg_port = p; cfg_addr = a;
        tick();
        cfg_rd_en = 1'b0;
        d = cfg_rdata;
        v = cfg_rvalid;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic v;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (txv[79:0] !== TX0_DEF) begin errors++; $display("FAIL reset_tx0 got %h want %h", txv[79:0], TX0_DEF); end
        checks++;
        if (rxv[79:0] !== RX0_DEF) begin errors++; $display("FAIL reset_rx0 got %h want %h", rxv[79:0], RX0_DEF); end
        checks++;
        if (txv[159:80] !== TX1_DEF) begin errors++; $display("FAIL reset_tx1 got %h want %h", txv[159:80], TX1_DEF); end
        checks++;
        if (cfg_busy !== 2'b00 || cfg_done !== 2'b00 || cfg_rvalid !== 1'b0 || cfg_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_ctl busy=%b done=%b rvalid=%b rdata=%h want 0", cfg_busy, cfg_done, cfg_rvalid, cfg_rdata);
        end
        rd(2'd0, 3'd2, d, v);
        checks++;
        if (d !== (RB ? 32'd1518 : 32'd0) || v !== RB) begin errors++; $display("FAIL reset_rd_mtu got %h/%b want %h/%b", d, v, RB ? 32'd1518 : 32'd0, RB); end
    endtask

    task automatic test_commit;
        int bad;
        wr(2'd0, 3'd2, 32'd9000);
        wr(2'd0, 3'd3, 32'h0000_000B);
        checks++;
        if (txv[79:0] !== TX0_DEF) begin errors++; $display("FAIL shadow_only got %h want %h", txv[79:0], TX0_DEF); end
        cfg_commit = 2'b01;
        tick();
        cfg_commit = 2'b00;
        bad = 0;
        for (int k = 1; k <= 17; k++) begin
            if (txv[1] !== 1'b0 || rxv[1] !== 1'b0 || cfg_done[0] !== 1'b0 || cfg_busy[0] !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL commit_window bad_cycles=%0d want 0", bad); end
        checks++;
        if (cfg_done[0] !== 1'b1) begin errors++; $display("FAIL commit_done_t18 got %b want 1", cfg_done[0]); end
        checks++;
        if (txv[79:0] !== {48'h001122334455, 1'b0, 15'd9000, 16'h0012}) begin
            errors++; $display("FAIL commit_tx got %h want %h", txv[79:0], {48'h001122334455, 1'b0, 15'd9000, 16'h0012});
        end
        checks++;
        if (rxv[79:0] !== {48'h001122334455, 1'b0, 15'd9000, 16'h0012}) begin
            errors++; $display("FAIL commit_rx got %h want %h", rxv[79:0], {48'h001122334455, 1'b0, 15'd9000, 16'h0012});
        end
        tick();
        checks++;
        if (cfg_done[0] !== 1'b0 || cfg_busy[0] !== 1'b0) begin errors++; $display("FAIL commit_after done=%b busy=%b want 0/0", cfg_done[0], cfg_busy[0]); end
    endtask

    task automatic test_busy_hold;
        int n;
        logic [31:0] d;
        logic v;
        mac_tx_busy[0] = 1'b1;
        cfg_commit = 2'b01;
        tick();
        cfg_commit = 2'b00;
        repeat (39) tick();
        tick();
        mac_tx_busy[0] = 1'b0;
        n = 0;
        while (cfg_done[0] !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n != 17) begin errors++; $display("FAIL busy_hold_latency got %0d want 17", n); end
        tick();
        rd(2'd0, 3'd4, d, v);
        checks++;
        if (d !== 32'h0 || v !== RB) begin errors++; $display("FAIL busy_hold_status got %h/%b want 0/%b", d, v, RB); end
    endtask

    task automatic test_timeout;
        int n;
        logic [31:0] d;
        logic v;
        mac_tx_busy[1] = 1'b1;
        cfg_commit = 2'b10;
        tick();
        cfg_commit = 2'b00;
        rd(2'd1, 3'd4, d, v);
        checks++;
        if (d !== (RB ? 32'h2 : 32'h0)) begin errors++; $display("FAIL quiesce_status got %h want %h", d, RB ? 32'h2 : 32'h0); end
        n = 1;
        while (cfg_done[1] !== 1'b1 && n < 300) begin tick(); n++; end
        checks++;
        if (n != 101) begin errors++; $display("FAIL timeout_latency got %0d want 101", n); end
        checks++;
        if (txv[159:80] !== TX1_DEF || cfg_done[0] !== 1'b0) begin errors++; $display("FAIL timeout_vec got %h done0=%b want %h 0", txv[159:80], cfg_done[0], TX1_DEF); end
        mac_tx_busy[1] = 1'b0;
        tick();
        rd(2'd1, 3'd4, d, v);
        checks++;
        if (d !== (RB ? 32'h1 : 32'h0)) begin errors++; $display("FAIL timeout_sticky got %h want %h", d, RB ? 32'h1 : 32'h0); end
        wr(2'd1, 3'd4, 32'h0);
        rd(2'd1, 3'd4, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL sticky_clear got %h want 0", d); end
    endtask

    task automatic test_back_to_back;
        int dones, d1, d2;
        wr(2'd0, 3'd2, 32'd1000);
        cfg_commit = 2'b01;
        tick();
        cfg_commit = 2'b00;
        tick(); tick();
        wr(2'd0, 3'd2, 32'd2000);
        tick();
        cfg_commit = 2'b01;
        tick();
        cfg_commit = 2'b00;
        dones = 0; d1 = 0; d2 = 0;
        for (int c = 6; c < 70; c++) begin
            if (cfg_done[0] === 1'b1) begin
                dones++;
                if (dones == 1) d1 = c; else d2 = c;
            end
            tick();
        end
        checks++;
        if (dones != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", dones); end
        checks++;
        if (d1 != 18 || d2 != 37) begin errors++; $display("FAIL b2b_timing got %0d,%0d want 18,37", d1, d2); end
        checks++;
        if (txv[30:16] !== 15'd2000) begin errors++; $display("FAIL b2b_mtu got %0d want 2000", txv[30:16]); end
    endtask

    task automatic test_same_cycle_and_bad_port;
        logic [31:0] d;
        logic v;
        wr(2'd2, 3'd2, 32'd123);
        wr(2'd3, 3'd2, 32'd456);
        wr(2'd0, 3'd5, 32'hFFFF_FFFF);
        rd(2'd0, 3'd5, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL addr5_read got %h want 0", d); end
        cfg_wr_en = 1'b1; cfg_port = 2'd0; cfg_addr = 3'd2; cfg_wdata = 32'hFFFF_8309;
        cfg_commit = 2'b11;
        tick();
        cfg_wr_en = 1'b0;
        cfg_commit = 2'b00;
        repeat (17) tick();
        checks++;
        if (cfg_done !== 2'b11) begin errors++; $display("FAIL same_cycle_done got %b want 11", cfg_done); end
        checks++;
        if (txv[30:16] !== 15'h0309 || txv[110:96] !== 15'd1518) begin
            errors++; $display("FAIL same_cycle_mtu got %h,%0d want 0309,1518", txv[30:16], txv[110:96]);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        wr(2'd0, 3'd0, 32'hDEAD_BEEF);
        cfg_commit = 2'b01;
        tick();
        cfg_commit = 2'b00;
        repeat (16) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (txv[79:0] !== TX0_DEF || rxv[79:0] !== RX0_DEF) begin
            errors++; $display("FAIL mid_reset_vec got %h/%h want %h/%h", txv[79:0], rxv[79:0], TX0_DEF, RX0_DEF);
        end
        checks++;
        if (cfg_busy !== 2'b00 || cfg_done !== 2'b00) begin errors++; $display("FAIL mid_reset_ctl busy=%b done=%b want 00/00", cfg_busy, cfg_done); end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (cfg_done !== 2'b00 || txv[79:0] !== TX0_DEF || txv[159:80] !== TX1_DEF) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL post_reset_quiet bad_cycles=%0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_busy_hold();
        test_timeout();
        test_back_to_back();
        test_same_cycle_and_bad_port();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_mac_conf_ctrl.md
# eth_mac_conf_ctrl

Runtime-programmable configuration controller for NPORT 10G Ethernet MAC instances. Holds a per-port shadow register set written over a simple word-addressed bus and drives each MAC's 80-bit TX and RX configuration vectors. Changes apply atomically through a per-port commit sequence that quiesces the MAC before reloading. It sits between the host-side control register bus and the MAC cores, and replaces fixed tie-off configuration.

## Interface
- NPORT, 1: number of MAC ports, 1..4
- DEFAULT_MAC, 48'h001122334455: reset MAC address; port p uses DEFAULT_MAC + p
- DEFAULT_MTU, 1518: reset max frame length, 15 bits
- QUIET_CYCLES, 16: consecutive idle cycles required before reload, ≥1
- TIMEOUT, 65535: maximum QUIESCE cycles before a forced reload, > QUIET_CYCLES
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- cfg_wr_en  in  1  write strobe
- cfg_rd_en  in  1  read strobe
- cfg_port  in  2  port select; ignored when ≥ NPORT
- cfg_addr  in  3  word address
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data
- cfg_rvalid  out  1  read data valid pulse
- cfg_commit  in  NPORT  per-port commit request pulse
- mac_tx_busy  in  NPORT  TX frame in progress
- mac_rx_busy  in  NPORT  RX frame in progress
- cfg_busy  out  NPORT  port not in IDLE or commit pending
- cfg_done  out  NPORT  one-cycle pulse when a commit completes
- mac_tx_configuration_vector  out  80*NPORT  port p occupies [80p+79:80p]
- mac_rx_configuration_vector  out  80*NPORT  same packing as TX

## Operation
- Register map, per port:
  - addr 0: MAC[31:0]
  - addr 1: MAC[47:32] in bits [15:0]
  - addr 2: MTU in bits [14:0]
  - addr 3 CTRL: b0 tx_en, b1 rx_en, b2 vlan, b3 jumbo, b4 rx_len_chk_dis, b5 rx_lt_chk_dis
  - addr 4 STATUS, read-only: b0 timeout_sticky (cleared by writing addr 4), b1 busy
  - addr 5–7: read 0, writes ignored
- CTRL resets to 6'b111111. The MTU register holds 15 bits; upper bits of writes are dropped.
- Vector packing:
  - [79:32] MAC, [30:16] MTU, [4] jumbo, [2] vlan, [1] enable (TX: tx_en, RX: rx_en)
  - RX only: [9] rx_len_chk_dis, [8] rx_lt_chk_dis
  - All other bits are 0, including TX [9:8].
- Writes update shadow registers only. Active vectors change only through a commit.
- Per-port FSM:
  - IDLE: cfg_commit or a pending flag → QUIESCE.
  - QUIESCE: active enable bits [1] forced to 0; counts consecutive cycles with tx_busy=0 and rx_busy=0. Count reaching QUIET_CYCLES → LOAD. Total QUIESCE cycles reaching TIMEOUT → LOAD and set timeout_sticky.
  - LOAD: active ← shadow snapshot with enables held at 0; 1 cycle; → ENABLE.
  - ENABLE: enable bits ← shadow tx_en/rx_en; pulse cfg_done; → IDLE.
- A commit outside IDLE sets pending; multiple commits merge into one pending flag.
- A busy input going high during QUIESCE resets the quiet count to 0.
- Reset, including mid-commit: all FSMs go to IDLE, pending cleared, shadow and active registers take defaults, enables 1, cfg_done 0, cfg_busy 0, cfg_rvalid 0, cfg_rdata 0.
- A simultaneous write and commit in the same cycle: the write lands in the shadow before the LOAD snapshot.

## Timing
- Reads: registered; cfg_rdata and cfg_rvalid are valid the cycle after cfg_rd_en.
- Commit latency with busy inputs low: commit at cycle t gives QUIESCE from t+1, LOAD at t+1+QUIET_CYCLES, cfg_done and enables restored one cycle after LOAD.
- Enable bits are low from t+1 through LOAD inclusive.

## Configuration
- ETH_MAC_CONF_READBACK_EN defined: the read path is implemented as specified.
- Not defined: cfg_rdata is tied to 0, cfg_rvalid to 0, and cfg_rd_en is ignored. Writes and commits are unaffected.

## Structure
- Shared package eth_mac_conf_pkg holds:
  - address constants ADDR_MAC_LO through ADDR_STATUS
  - CTRL bit indices
  - vector bit-position constants
  - FSM state enum
- Sub-module eth_mac_conf_port: one port's shadow registers, FSM, counters and vector packing; instantiated NPORT times.
- The top level decodes cfg_port and muxes read data.

## Test plan
- Reset → port 0 TX vector = {48'h001122334455, 1'b0, 15'd1518, 16'h0016}; port 1 MAC field = 48'h001122334456.
- Write MTU 9000 and CTRL 6'b001011, then commit with busy low → TX and RX [1] low for 17 cycles; after commit, MTU field = 9000, jumbo = 1, vlan = 0, TX RX [9:8] = 2'b00; cfg_done pulses once at t+18.
- Hold mac_tx_busy high for 40 cycles after commit → LOAD occurs exactly 16 cycles after busy falls; no timeout flag.
- Hold busy high permanently with TIMEOUT = 100 → forced LOAD after 100 QUIESCE cycles; STATUS reads 0x1; a write to addr 4 clears it.
- Issue a second commit during QUIESCE → exactly two cfg_done pulses; the second commit loads values written between the two commits.
- Assert rst during LOAD → all vectors return to defaults immediately; cfg_busy = 0; no cfg_done pulse.
